// File: rtl/br_update_queue_pkg.sv
// br_pkg: shared types and constants for the branch update queue.
//   BR_INDEX_WIDTH - default PHT index / GHR width; also the width of the
//                    stored index field, so INDEX_WIDTH must not exceed it
//   br_entry_t     - one in-flight branch: the PHT row read at fetch and the
//                    prediction taken from that row
//   BR_SNT..BR_ST  - 2-bit saturating counter states of a PHT row
package br_pkg;
    localparam int BR_INDEX_WIDTH = 12;
    localparam logic [1:0] BR_SNT = 2'b00;
    localparam logic [1:0] BR_WNT = 2'b01;
    localparam logic [1:0] BR_WT  = 2'b10;
    localparam logic [1:0] BR_ST  = 2'b11;
    typedef struct packed {
        logic [BR_INDEX_WIDTH-1:0] index;
        logic                      pred;
    } br_entry_t;
endpackage

// File: rtl/br_update_queue_ghr.sv
// br_ghr: speculative and committed global history registers.
//   clk_i, rst_ni       - clock, async active-low reset
//   spec_shift_i/bit_i  - shift a predicted direction into the speculative GHR
//   commit_shift_i/bit_i- shift a resolved direction into the committed GHR
//   restore_i           - reload the speculative GHR from the committed GHR,
//                         including any same-cycle commit shift
//   spec_ghr_o          - speculative GHR used to hash the PHT read index
module br_ghr #(
    parameter int INDEX_WIDTH = br_pkg::BR_INDEX_WIDTH
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   spec_shift_i,
    input  logic                   spec_bit_i,
    input  logic                   commit_shift_i,
    input  logic                   commit_bit_i,
    input  logic                   restore_i,
    output logic [INDEX_WIDTH-1:0] spec_ghr_o
);
    logic [INDEX_WIDTH-1:0] commit_ghr;
    logic [INDEX_WIDTH-1:0] commit_nxt;

    assign commit_nxt = commit_shift_i ? {commit_ghr[INDEX_WIDTH-2:0], commit_bit_i} : commit_ghr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            commit_ghr <= '0;
            spec_ghr_o <= '0;
        end else begin
            commit_ghr <= commit_nxt;
            spec_ghr_o <= restore_i    ? commit_nxt :
                          spec_shift_i ? {spec_ghr_o[INDEX_WIDTH-2:0], spec_bit_i} : spec_ghr_o;
        end
    end
endmodule

// File: rtl/br_update_queue.sv
// br_update_queue: in-order queue of in-flight gshare branches that issues
// PHT updates at resolve and repairs the speculative history on mispredict.
//   clk_i, rst_ni              - clock, async active-low reset
//   alloc_valid_i/pc_idx_i/pred_i, alloc_ready_o - fetch-side allocation
//   rd_index_o                 - gshare PHT read index (pc_idx ^ spec_ghr)
//   resolve_valid_i/taken_i    - in-order resolution of the oldest branch
//   flush_i                    - external pipeline flush
//   mispredict_o               - head prediction differs from resolved outcome
//   update_en_o/index_o, br_taken_o - registered PHT update, one cycle after resolve
//   count_o                    - occupied entries
//   perf_resolved_o/mispred_o  - saturating counters, present only when
//                                BR_UPDATE_QUEUE_PERF_CNT_EN is defined
module br_update_queue
    import br_pkg::*;
#(
    parameter int INDEX_WIDTH = BR_INDEX_WIDTH,
    parameter int DEPTH       = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     alloc_valid_i,
    input  logic [INDEX_WIDTH-1:0]   alloc_pc_idx_i,
    input  logic                     alloc_pred_i,
    output logic                     alloc_ready_o,
    output logic [INDEX_WIDTH-1:0]   rd_index_o,
    input  logic                     resolve_valid_i,
    input  logic                     resolve_taken_i,
    input  logic                     flush_i,
    output logic                     mispredict_o,
    output logic                     update_en_o,
    output logic [INDEX_WIDTH-1:0]   update_index_o,
    output logic                     br_taken_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [31:0]              perf_resolved_o,
    output logic [31:0]              perf_mispred_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    br_entry_t              mem [DEPTH];
    br_entry_t              head;
    logic [PW-1:0]          head_ptr, tail_ptr;
    logic [INDEX_WIDTH-1:0] spec_ghr;
    logic                   res_acc, alloc_acc, clear;

    assign head          = mem[head_ptr];
    assign rd_index_o    = alloc_pc_idx_i ^ spec_ghr;
    assign alloc_ready_o = count_o != CW'(DEPTH);
    assign res_acc       = resolve_valid_i & (count_o != '0);
    assign mispredict_o  = res_acc & (head.pred != resolve_taken_i);
    assign clear         = flush_i | mispredict_o;
    // A correct resolve frees the head slot this cycle, so a full queue may
    // still take an allocation alongside it.
    assign alloc_acc     = alloc_valid_i & ~clear & (alloc_ready_o | res_acc);

    br_ghr #(.INDEX_WIDTH(INDEX_WIDTH)) u_ghr (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .spec_shift_i  (alloc_acc),
        .spec_bit_i    (alloc_pred_i),
        .commit_shift_i(res_acc),
        .commit_bit_i  (resolve_taken_i),
        .restore_i     (clear),
        .spec_ghr_o    (spec_ghr)
    );

    always_ff @(posedge clk_i) begin
        if (alloc_acc) mem[tail_ptr] <= '{index: BR_INDEX_WIDTH'(rd_index_o), pred: alloc_pred_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_ptr       <= '0;
            tail_ptr       <= '0;
            count_o        <= '0;
            update_en_o    <= 1'b0;
            update_index_o <= '0;
            br_taken_o     <= 1'b0;
        end else begin
            if (clear) begin
                head_ptr <= '0;
                tail_ptr <= '0;
                count_o  <= '0;
            end else begin
                if (alloc_acc) tail_ptr <= tail_ptr + PW'(1);
                if (res_acc) head_ptr <= head_ptr + PW'(1);
                count_o <= count_o + CW'(alloc_acc) - CW'(res_acc);
            end
            update_en_o <= res_acc;
            if (res_acc) begin
                update_index_o <= INDEX_WIDTH'(head.index);
                br_taken_o     <= resolve_taken_i;
            end
        end
    end

`ifdef BR_UPDATE_QUEUE_PERF_CNT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_resolved_o <= '0;
            perf_mispred_o  <= '0;
        end else begin
            if (res_acc && !(&perf_resolved_o)) perf_resolved_o <= perf_resolved_o + 32'd1;
            if (mispredict_o && !(&perf_mispred_o)) perf_mispred_o <= perf_mispred_o + 32'd1;
        end
    end
`else
    assign perf_resolved_o = '0;
    assign perf_mispred_o  = '0;
`endif
endmodule

// File: tb/tb_br_update_queue.sv
// tb_br_update_queue: randomized and directed checks of br_update_queue
// against a queue-based reference model.
module tb_br_update_queue;
    localparam int IW = 12;
    localparam int D  = 8;
    localparam int CW = 4;

    logic          clk_i = 0, rst_ni = 0;
    logic          alloc_valid_i = 0, alloc_pred_i = 0, resolve_valid_i = 0, resolve_taken_i = 0, flush_i = 0;
    logic [IW-1:0] alloc_pc_idx_i = '0;
    logic          alloc_ready_o, mispredict_o, update_en_o, br_taken_o;
    logic [IW-1:0] rd_index_o, update_index_o;
    logic [CW-1:0] count_o;
    logic [31:0]   perf_resolved_o, perf_mispred_o;

    always #5 clk_i = ~clk_i;

    br_update_queue #(.INDEX_WIDTH(IW), .DEPTH(D)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .alloc_valid_i(alloc_valid_i), .alloc_pc_idx_i(alloc_pc_idx_i), .alloc_pred_i(alloc_pred_i),
        .alloc_ready_o(alloc_ready_o), .rd_index_o(rd_index_o),
        .resolve_valid_i(resolve_valid_i), .resolve_taken_i(resolve_taken_i), .flush_i(flush_i),
        .mispredict_o(mispredict_o), .update_en_o(update_en_o), .update_index_o(update_index_o),
        .br_taken_o(br_taken_o), .count_o(count_o),
        .perf_resolved_o(perf_resolved_o), .perf_mispred_o(perf_mispred_o)
    );

    typedef struct { logic [IW-1:0] idx; logic pred; } ent_t;
    ent_t          q[$];
    logic [IW-1:0] sg, cg, m_idx;
    logic          m_en, m_tk;
    logic [31:0]   m_pr, m_pm;
    int            checks = 0, failures = 0;

    task automatic model_reset();
        q.delete();
        sg = '0; cg = '0; m_idx = '0; m_en = 0; m_tk = 0; m_pr = '0; m_pm = '0;
    endtask

    task automatic idle();
        alloc_valid_i = 0; alloc_pred_i = 0; alloc_pc_idx_i = '0;
        resolve_valid_i = 0; resolve_taken_i = 0; flush_i = 0;
    endtask

    // Advance one clock, updating the model from the inputs held this cycle.
    task automatic cycle();
        bit res, mis, acc;
        logic [IW-1:0] cg_n;
        ent_t h;
        res  = resolve_valid_i && q.size() != 0;
        mis  = res && (q[0].pred != resolve_taken_i);
        acc  = alloc_valid_i && !flush_i && !mis && (q.size() != D || res);
        cg_n = res ? {cg[IW-2:0], resolve_taken_i} : cg;
        m_en = res;
        if (res) begin
            h = q.pop_front();
            m_idx = h.idx;
            m_tk = resolve_taken_i;
`ifdef BR_UPDATE_QUEUE_PERF_CNT_EN
            if (m_pr != 32'hFFFF_FFFF) m_pr++;
            if (mis && m_pm != 32'hFFFF_FFFF) m_pm++;
`endif
        end
        if (acc) begin
            q.push_back('{alloc_pc_idx_i ^ sg, alloc_pred_i});
            sg = {sg[IW-2:0], alloc_pred_i};
        end
        if (flush_i || mis) begin
            q.delete();
            sg = cg_n;
        end
        cg = cg_n;
        @(posedge clk_i);
        #1;
    endtask

    task automatic empty_queue();
        idle(); flush_i = 1; cycle(); idle();
    endtask

    task automatic test_reset();
        rst_ni = 0; model_reset(); idle();
        alloc_pc_idx_i = 12'h3a5;
        #3;
        checks++; if (count_o !== 0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count_o); end
        checks++; if (alloc_ready_o !== 1) begin failures++; $display("FAIL reset_ready got=%b exp=1", alloc_ready_o); end
        checks++; if (update_en_o !== 0 || update_index_o !== 0 || br_taken_o !== 0) begin failures++; $display("FAIL reset_update got=%b/%0h/%b exp=0/0/0", update_en_o, update_index_o, br_taken_o); end
        checks++; if (perf_resolved_o !== 0 || perf_mispred_o !== 0) begin failures++; $display("FAIL reset_perf got=%0d/%0d exp=0/0", perf_resolved_o, perf_mispred_o); end
        checks++; if (rd_index_o !== 12'h3a5) begin failures++; $display("FAIL reset_rd_index got=%0h exp=3a5", rd_index_o); end
        @(posedge clk_i); #1;
        rst_ni = 1; idle();
    endtask

    task automatic test_ghr_index();
        empty_queue();
        alloc_valid_i = 1; alloc_pc_idx_i = 12'h005; alloc_pred_i = 1;
        #1;
        checks++; if (rd_index_o !== 12'h005) begin failures++; $display("FAIL ghr_rd_first got=%0h exp=005", rd_index_o); end
        cycle();
        alloc_valid_i = 0;
        #1;
        checks++; if (rd_index_o !== 12'h004) begin failures++; $display("FAIL ghr_rd_second got=%0h exp=004", rd_index_o); end
        checks++; if (count_o !== 1) begin failures++; $display("FAIL ghr_count got=%0d exp=1", count_o); end
    endtask

    task automatic test_full();
        empty_queue();
        alloc_valid_i = 1; alloc_pred_i = 0;
        for (int i = 0; i < D; i++) begin alloc_pc_idx_i = IW'($urandom); cycle(); end
        checks++; if (count_o !== 8 || alloc_ready_o !== 0) begin failures++; $display("FAIL full_state got=%0d/%b exp=8/0", count_o, alloc_ready_o); end
        alloc_pc_idx_i = IW'($urandom); cycle();
        checks++; if (count_o !== 8) begin failures++; $display("FAIL full_ninth_alloc got=%0d exp=8", count_o); end
        resolve_valid_i = 1; resolve_taken_i = 0;
        #1;
        checks++; if (mispredict_o !== 0) begin failures++; $display("FAIL full_mispredict got=%b exp=0", mispredict_o); end
        cycle();
        checks++; if (count_o !== 8) begin failures++; $display("FAIL full_alloc_resolve_count got=%0d exp=8", count_o); end
        checks++; if (update_en_o !== 1 || update_index_o !== m_idx) begin failures++; $display("FAIL full_update got=%b/%0h exp=1/%0h", update_en_o, update_index_o, m_idx); end
    endtask

    task automatic test_resolve_correct();
        logic [IW-1:0] exp_idx;
        empty_queue();
        alloc_valid_i = 1; alloc_pc_idx_i = 12'h9c3; alloc_pred_i = 1;
        exp_idx = 12'h9c3 ^ sg;
        cycle();
        idle(); resolve_valid_i = 1; resolve_taken_i = 1;
        #1;
        checks++; if (mispredict_o !== 0) begin failures++; $display("FAIL correct_mispredict got=%b exp=0", mispredict_o); end
        cycle();
        idle();
        checks++; if (update_en_o !== 1 || update_index_o !== exp_idx || br_taken_o !== 1) begin failures++; $display("FAIL correct_update got=%b/%0h/%b exp=1/%0h/1", update_en_o, update_index_o, br_taken_o, exp_idx); end
        cycle();
        checks++; if (update_en_o !== 0 || update_index_o !== exp_idx) begin failures++; $display("FAIL correct_hold got=%b/%0h exp=0/%0h", update_en_o, update_index_o, exp_idx); end
    endtask

    task automatic test_mispredict();
        logic [IW-1:0] cg_before, exp_idx;
        logic [2:0] preds;
        empty_queue();
        preds = 3'b110;
        alloc_valid_i = 1;
        for (int i = 0; i < 3; i++) begin alloc_pc_idx_i = IW'($urandom); alloc_pred_i = preds[i]; cycle(); end
        idle(); resolve_valid_i = 1; resolve_taken_i = 1;
        alloc_valid_i = 1; alloc_pc_idx_i = 12'h111; alloc_pred_i = 1;
        cg_before = cg; exp_idx = q[0].idx;
        #1;
        checks++; if (mispredict_o !== 1) begin failures++; $display("FAIL mis_flag got=%b exp=1", mispredict_o); end
        cycle();
        idle();
        #1;
        checks++; if (count_o !== 0) begin failures++; $display("FAIL mis_count got=%0d exp=0", count_o); end
        checks++; if (update_en_o !== 1 || update_index_o !== exp_idx || br_taken_o !== 1) begin failures++; $display("FAIL mis_update got=%b/%0h/%b exp=1/%0h/1", update_en_o, update_index_o, br_taken_o, exp_idx); end
        checks++; if (rd_index_o !== {cg_before[IW-2:0], 1'b1}) begin failures++; $display("FAIL mis_spec_ghr got=%0h exp=%0h", rd_index_o, {cg_before[IW-2:0], 1'b1}); end
    endtask

    task automatic test_flush();
        logic [IW-1:0] exp_idx;
        empty_queue();
        alloc_valid_i = 1; alloc_pred_i = 0;
        for (int i = 0; i < 2; i++) begin alloc_pc_idx_i = IW'($urandom); cycle(); end
        exp_idx = q[0].idx;
        alloc_pc_idx_i = 12'h7e1; resolve_valid_i = 1; resolve_taken_i = 0; flush_i = 1;
        cycle();
        idle();
        checks++; if (count_o !== 0) begin failures++; $display("FAIL flush_count got=%0d exp=0", count_o); end
        checks++; if (update_en_o !== 1 || update_index_o !== exp_idx || br_taken_o !== 0) begin failures++; $display("FAIL flush_update got=%b/%0h/%b exp=1/%0h/0", update_en_o, update_index_o, br_taken_o, exp_idx); end
    endtask

    task automatic test_random();
        logic [IW-1:0] e_rd;
        logic e_mis;
        empty_queue();
        for (int n = 0; n < 600; n++) begin
            alloc_valid_i   = $urandom_range(0, 99) < 70;
            alloc_pc_idx_i  = IW'($urandom);
            alloc_pred_i    = 1'($urandom);
            resolve_valid_i = $urandom_range(0, 99) < 45;
            resolve_taken_i = 1'($urandom);
            flush_i         = $urandom_range(0, 99) < 3;
            #1;
            e_rd  = alloc_pc_idx_i ^ sg;
            e_mis = resolve_valid_i && q.size() != 0 && q[0].pred != resolve_taken_i;
            checks++; if (rd_index_o !== e_rd) begin failures++; $display("FAIL rnd_rd_index n=%0d got=%0h exp=%0h", n, rd_index_o, e_rd); end
            checks++; if (mispredict_o !== e_mis) begin failures++; $display("FAIL rnd_mispredict n=%0d got=%b exp=%b", n, mispredict_o, e_mis); end
            checks++; if (count_o !== CW'(q.size()) || alloc_ready_o !== (q.size() != D)) begin failures++; $display("FAIL rnd_count n=%0d got=%0d/%b exp=%0d", n, count_o, alloc_ready_o, q.size()); end
            cycle();
            checks++; if (update_en_o !== m_en || update_index_o !== m_idx || br_taken_o !== m_tk) begin failures++; $display("FAIL rnd_update n=%0d got=%b/%0h/%b exp=%b/%0h/%b", n, update_en_o, update_index_o, br_taken_o, m_en, m_idx, m_tk); end
            checks++; if (perf_resolved_o !== m_pr || perf_mispred_o !== m_pm) begin failures++; $display("FAIL rnd_perf n=%0d got=%0d/%0d exp=%0d/%0d", n, perf_resolved_o, perf_mispred_o, m_pr, m_pm); end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        empty_queue();
        alloc_valid_i = 1; alloc_pred_i = 1;
        for (int i = 0; i < 4; i++) begin alloc_pc_idx_i = IW'($urandom); cycle(); end
        idle(); resolve_valid_i = 1; resolve_taken_i = 1;
        #2;
        rst_ni = 0; model_reset();
        #1;
        checks++; if (count_o !== 0 || alloc_ready_o !== 1) begin failures++; $display("FAIL rstmid_queue got=%0d/%b exp=0/1", count_o, alloc_ready_o); end
        checks++; if (update_en_o !== 0 || update_index_o !== 0 || br_taken_o !== 0) begin failures++; $display("FAIL rstmid_update got=%b/%0h/%b exp=0/0/0", update_en_o, update_index_o, br_taken_o); end
        checks++; if (mispredict_o !== 0 || perf_resolved_o !== 0) begin failures++; $display("FAIL rstmid_misc got=%b/%0d exp=0/0", mispredict_o, perf_resolved_o); end
        @(posedge clk_i); #1;
        rst_ni = 1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++; if (update_en_o !== 0 || count_o !== 0) begin failures++; $display("FAIL rstmid_after i=%0d got=%b/%0d exp=0/0", i, update_en_o, count_o); end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_ghr_index();
        test_full();
        test_resolve_correct();
        test_mispredict();
        test_flush();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
